// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: sequential shift-add multiplier (control FSM + A/B/X datapath).
// The multiplicand is latched from S at start; the multiplier sits in B and the
// 2*WIDTH-bit product ends up in {A,B} after WIDTH compute cycles.
//
// Build option: define SEQMUL_SIGNED_EN for two's-complement operands (sign-extended
// accumulation, subtract on the last bit, X tracks the sign). Without it the
// operands are unsigned, the carry shifts into A[WIDTH-1] and X stays 0.
//
// state   | meaning
// IDLE    | waiting; ClearA_LoadB clears A/X and loads B, Run starts
// COMPUTE | one multiplier bit per cycle, WIDTH cycles, inputs ignored
// DONE    | result held until Run is released
module seq_multiplier_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             last;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   mext;
  logic [WIDTH:0]   sum;
  logic             x_upd;

  // One partial-product step: conditionally accumulate the multiplicand into A.
  always_comb begin
    last = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SEQMUL_SIGNED_EN
    // Multiplier MSB carries negative weight, hence the subtract on the last bit.
    ext   = {a_q[WIDTH-1], a_q};
    mext  = {m_q[WIDTH-1], m_q};
    sum   = b_q[0] ? (last ? (ext - mext) : (ext + mext)) : ext;
    x_upd = sum[WIDTH];
`else
    ext   = {1'b0, a_q};
    mext  = {1'b0, m_q};
    sum   = b_q[0] ? (ext + mext) : ext;
    x_upd = 1'b0;
`endif
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end else if (Run) begin
          m_d     = S;
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        x_d   = x_upd;
        a_d   = sum[WIDTH:1];
        b_d   = {sum[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
      end
      DONE: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign X    = x_q;
  assign Busy = (state_q == COMPUTE);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n (WIDTH=8). Expected products are hand
// computed for both the signed (SEQMUL_SIGNED_EN) and the unsigned build.
module tb_seq_multiplier_n;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Run;
  logic         ClearA_LoadB;
  logic [W-1:0] S;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         X;
  logic         Busy;
  logic         Done;

  int n_vec = 0;
  int n_err = 0;

`ifdef SEQMUL_SIGNED_EN
  localparam logic [2*W-1:0] P_FD_07 = 16'hFFEB;  // -3 * 7
  localparam logic           X_FD_07 = 1'b1;
  localparam logic [2*W-1:0] P_EB_02 = 16'hFFD6;  // -21 * 2
  localparam logic           X_EB_02 = 1'b1;
  localparam logic [2*W-1:0] P_80_80 = 16'h4000;  // -128 * -128
  localparam logic [2*W-1:0] P_80_01 = 16'hFF80;  // -128 * 1
  localparam logic           X_80_01 = 1'b1;
  localparam logic [2*W-1:0] P_FF_FF = 16'h0001;  // -1 * -1
`else
  localparam logic [2*W-1:0] P_FD_07 = 16'h06EB;  // 253 * 7
  localparam logic           X_FD_07 = 1'b0;
  localparam logic [2*W-1:0] P_EB_02 = 16'h01D6;  // 235 * 2
  localparam logic           X_EB_02 = 1'b0;
  localparam logic [2*W-1:0] P_80_80 = 16'h4000;  // 128 * 128
  localparam logic [2*W-1:0] P_80_01 = 16'h0080;  // 128 * 1
  localparam logic           X_80_01 = 1'b0;
  localparam logic [2*W-1:0] P_FF_FF = 16'hFE01;  // 255 * 255
`endif

  always #5 Clk = ~Clk;

  seq_multiplier_n #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .A            (A),
    .B            (B),
    .X            (X),
    .Busy         (Busy),
    .Done         (Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic load_b(input logic [W-1:0] s);
    @(negedge Clk);
    S            = s;
    ClearA_LoadB = 1'b1;
    Run          = 1'b1;  // load must win over Run
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    check("load B", B, s);
    check("load A", A, 0);
    check("load busy", Busy, 0);
  endtask

  // Starts a multiply, counts Busy cycles, checks the result and the Done handshake.
  task automatic mult(input string tag, input logic [W-1:0] s,
                      input logic [2*W-1:0] prod, input logic xw);
    int busy_n;
    busy_n = 0;
    @(negedge Clk);
    S   = s;
    Run = 1'b1;
    @(negedge Clk);
    S = ~s;  // multiplicand is latched, later S must not matter
    while (Busy === 1'b1 && busy_n < 4 * W) begin
      busy_n++;
      @(negedge Clk);
    end
    check({tag, " busy cycles"}, busy_n, W);
    check({tag, " done"}, Done, 1);
    check({tag, " product"}, {A, B}, prod);
    check({tag, " x"}, X, xw);
    @(negedge Clk);
    check({tag, " done hold"}, Done, 1);
    Run = 1'b0;
    @(negedge Clk);
    check({tag, " back idle"}, {Busy, Done}, 0);
    check({tag, " product kept"}, {A, B}, prod);
  endtask

  initial begin
    int guard;
    int done_n;
    Reset_n      = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = '0;
    #12;
    check("reset outputs", {A, B, X, Busy, Done}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // -3 * 7, then repeat run reusing low half as multiplier
    load_b(8'hFD);
    mult("fd*07", 8'h07, P_FD_07, X_FD_07);
    mult("repeat eb*02", 8'h02, P_EB_02, X_EB_02);

    load_b(8'h80);
    mult("80*80", 8'h80, P_80_80, 1'b0);
    load_b(8'h80);
    mult("80*01", 8'h01, P_80_01, X_80_01);
    load_b(8'hFF);
    mult("ff*ff", 8'hFF, P_FF_FF, 1'b0);

    // Disturbance: S change, load request and Run release during COMPUTE
    load_b(8'h05);
    @(negedge Clk);
    S   = 8'h03;
    Run = 1'b1;
    repeat (3) @(negedge Clk);
    S            = 8'hFF;
    ClearA_LoadB = 1'b1;
    Run          = 1'b0;
    guard = 0;
    while (Done !== 1'b1 && guard < 4 * W) begin
      guard++;
      @(negedge Clk);
    end
    check("disturb done", Done, 1);
    check("disturb product", {A, B}, 16'h000F);
    ClearA_LoadB = 1'b0;
    done_n = 0;
    while (Done === 1'b1 && done_n < 4) begin
      done_n++;
      @(negedge Clk);
    end
    check("disturb done length", done_n, 1);
    check("disturb idle", {Busy, Done}, 0);
    @(negedge Clk);
    check("disturb B kept", B, 8'h0F);

    // Async reset at cnt=3 of a COMPUTE
    load_b(8'h07);
    @(negedge Clk);
    S   = 8'h03;
    Run = 1'b1;
    @(negedge Clk);
    repeat (3) @(negedge Clk);
    check("pre-reset busy", Busy, 1);
    Reset_n = 1'b0;
    Run     = 1'b0;
    #1;
    check("reset mid-compute", {A, B, X, Busy, Done}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("post-reset quiet", {A, B, X, Busy, Done}, 0);
    load_b(8'h03);
    mult("post-reset 03*05", 8'h05, 16'h000F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
